// File: rtl/mmio_cpl_pkg.sv
// Shared types for the MMIO completion builder: read metadata, completion header layout,
// FSM states and the header assembly helper.
package mmio_cpl_pkg;

    localparam logic [7:0] CPL_FMTTYPE_CPLD = 8'h4A;
    localparam logic [7:0] CPL_FMTTYPE_CPL  = 8'h0A;
    localparam logic [2:0] CPL_STS_SC       = 3'b000;
    localparam logic [2:0] CPL_STS_UR       = 3'b001;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

    typedef struct packed {
        logic [9:0]  tag;
        logic [1:0]  length;
        logic [15:0] req_id;
        logic [6:0]  lower_addr;
        logic [2:0]  attr;
        logic [2:0]  tc;
    } t_cpl_meta;

    // 3DW completion header in PCIe DW order: DW0 occupies bits [31:0], DW2 bits [95:64].
    typedef struct packed {
        logic [159:0] rsvd_hi;
        logic [15:0]  req_id;
        logic [7:0]   tag_lo;
        logic         rsvd_dw2;
        logic [6:0]   lower_addr;
        logic [15:0]  completer_id;
        logic [2:0]   status;
        logic         bcm;
        logic [11:0]  byte_count;
        logic [7:0]   fmttype;
        logic         tag9;
        logic [2:0]   tc;
        logic         tag8;
        logic         attr_ido;
        logic         ln;
        logic         th;
        logic         td;
        logic         ep;
        logic [1:0]   attr_ro_ns;
        logic [1:0]   at;
        logic [9:0]   length;
    } t_cpl_hdr;

    typedef enum logic [0:0] {
        CPL_IDLE = 1'b0,
        CPL_SEND = 1'b1
    } t_cpl_state;

    function automatic t_cpl_hdr func_build_cpl_hdr(
        input t_cpl_meta   meta,
        input logic        rsp_ok,
        input logic [15:0] completer_id
    );
        t_cpl_hdr hdr;
        hdr              = '0;
        hdr.fmttype      = rsp_ok ? CPL_FMTTYPE_CPLD : CPL_FMTTYPE_CPL;
        hdr.tag9         = meta.tag[9];
        hdr.tag8         = meta.tag[8];
        hdr.tag_lo       = meta.tag[7:0];
        hdr.tc           = meta.tc;
        hdr.attr_ido     = meta.attr[2];
        hdr.attr_ro_ns   = meta.attr[1:0];
        hdr.length       = rsp_ok ? {8'd0, meta.length} : 10'd0;
        hdr.completer_id = completer_id;
        hdr.status       = rsp_ok ? CPL_STS_SC : CPL_STS_UR;
        hdr.byte_count   = {8'd0, meta.length, 2'b00};
        hdr.req_id       = meta.req_id;
        hdr.lower_addr   = meta.lower_addr;
        return hdr;
    endfunction

endpackage

// File: rtl/mmio_cpl_builder_meta_fifo.sv
// Synchronous FIFO of read metadata; a pop frees a slot for a push in the same cycle.
module mmio_cpl_meta_fifo
    import mmio_cpl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  t_cpl_meta              push_data_i,
    input  logic                   pop_i,
    output t_cpl_meta              pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    t_cpl_meta     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/mmio_cpl_builder.sv
// Pairs in-order AXI-lite R beats with captured read metadata and emits one single-beat
// PCIe completion TLP per read on an AXI-stream source.
module mmio_cpl_builder
    import mmio_cpl_pkg::*;
#(
    parameter int          MM_DATA_WIDTH = 64,
    parameter int          META_DEPTH    = 4,
    parameter int          TDATA_WIDTH   = 512,
    parameter logic [15:0] COMPLETER_ID  = 16'h0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_tlp_rd,
    input  logic [9:0]                  i_tlp_rd_tag,
    input  logic [1:0]                  i_tlp_rd_length,
    input  logic [15:0]                 i_tlp_rd_req_id,
    input  logic [6:0]                  i_tlp_rd_lower_addr,
    input  logic [2:0]                  i_tlp_attr,
    input  logic [2:0]                  i_tlp_tc,
    input  logic                        i_rvalid,
    output logic                        o_rready,
    input  logic [MM_DATA_WIDTH-1:0]    i_rdata,
    input  logic [1:0]                  i_rresp,
    output logic                        o_cpl_tvalid,
    input  logic                        i_cpl_tready,
    output logic [TDATA_WIDTH-1:0]      o_cpl_tdata,
    output logic [TDATA_WIDTH/8-1:0]    o_cpl_tkeep,
    output logic                        o_cpl_tlast,
    output logic                        o_err_meta_ovf,
    output logic                        o_err_orphan_rsp,
    output logic                        o_dbg_state,
    output logic [$clog2(META_DEPTH):0] o_dbg_meta_count
);

    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

    t_cpl_state             state_q;
    t_cpl_meta              push_meta, pop_meta;
    logic                   fifo_full, fifo_empty;
    logic                   r_hs, rsp_ok;
    logic [TDATA_WIDTH-1:0] tdata_d, tdata_q;
    logic [KEEP_WIDTH-1:0]  tkeep_d, tkeep_q;
    logic                   tvalid_q;
    logic                   meta_ovf_q, orphan_q;

    assign push_meta = '{tag:        i_tlp_rd_tag,
                         length:     i_tlp_rd_length,
                         req_id:     i_tlp_rd_req_id,
                         lower_addr: i_tlp_rd_lower_addr,
                         attr:       i_tlp_attr,
                         tc:         i_tlp_tc};

    mmio_cpl_meta_fifo #(
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (i_tlp_rd),
        .push_data_i (push_meta),
        .pop_i       (r_hs),
        .pop_data_o  (pop_meta),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (o_dbg_meta_count)
    );

    // Both interfaces transfer on a cycle where valid && ready; ready never depends on valid,
    // and a source keeps valid and its payload stable until the transfer happens.
    assign o_rready = (state_q == CPL_IDLE) && !fifo_empty;
    assign r_hs     = i_rvalid && o_rready;
    assign rsp_ok   = (i_rresp == AXI_RESP_OKAY);

    always_comb begin
        tdata_d        = '0;
        tkeep_d        = '0;
        tdata_d[255:0] = func_build_cpl_hdr(pop_meta, rsp_ok, COMPLETER_ID);
        if (!rsp_ok) begin
            tkeep_d[31:0] = '1;
        end else if (pop_meta.length == 2'd2) begin
            tdata_d[256 +: 64] = i_rdata[63:0];
            tkeep_d[39:0]      = '1;
        end else begin
            // A 1DW read returns the DW selected by address bit 2 of the 8-byte beat.
            tdata_d[256 +: 32] = pop_meta.lower_addr[2] ? i_rdata[63:32] : i_rdata[31:0];
            tkeep_d[35:0]      = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CPL_IDLE;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
        end else begin
            case (state_q)
                CPL_IDLE: begin
                    if (r_hs) begin
                        state_q  <= CPL_SEND;
                        tvalid_q <= 1'b1;
                        tdata_q  <= tdata_d;
                        tkeep_q  <= tkeep_d;
                    end
                end
                CPL_SEND: begin
                    if (i_cpl_tready) begin
                        state_q  <= CPL_IDLE;
                        tvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= CPL_IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_ovf_q <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            meta_ovf_q <= meta_ovf_q | (i_tlp_rd & fifo_full & ~r_hs);
            orphan_q   <= orphan_q | (i_rvalid & fifo_empty);
        end
    end

    assign o_cpl_tvalid     = tvalid_q;
    assign o_cpl_tlast      = tvalid_q;
    assign o_cpl_tdata      = tdata_q;
    assign o_cpl_tkeep      = tkeep_q;
    assign o_err_meta_ovf   = meta_ovf_q;
    assign o_err_orphan_rsp = orphan_q;
    assign o_dbg_state      = (state_q == CPL_SEND);

endmodule
